// File: rtl/store_buffer_ctrl.sv
// store_buffer_ctrl
//   Posted-write buffer between the MEM-stage store path and the data-memory
//   write port. Stores (SW/SH/SB) are decoded into byte enables and
//   lane-replicated data, queued in a DEPTH-entry FIFO, and drained in order
//   with a mem_req/mem_ack handshake. Misaligned stores are flagged and never
//   queued. Loads whose word matches a queued entry raise ld_hazard.
//
// Ports
//   clk, reset (async, active-low)
//   st_valid/st_ready/st_type/st_addr/st_data : store request from MEM stage
//   st_align_err                              : misaligned legal store presented
//   mem_req/mem_addr/mem_wdata/mem_byteen     : head entry write request
//   mem_ack                                   : memory accepted head write
//   ld_valid/ld_addr/ld_hazard                : pending-store load hazard check
//   count/empty                               : occupancy
module store_buffer_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [5:0]    st_type,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    output logic          st_align_err,
    output logic          mem_req,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_byteen,
    input  logic          mem_ack,
    input  logic          ld_valid,
    input  logic [31:0]   ld_addr,
    output logic          ld_hazard,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int unsigned PW = CW - 1;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SB = 6'b101000;

    logic [29:0]   addrQ [DEPTH];
    logic [31:0]   dataQ [DEPTH];
    logic [3:0]    beQ   [DEPTH];
    logic [DEPTH-1:0] validQ;
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;

    logic       isSw, isSh, isSb, isLegal, isAligned;
    logic       doPush, doPop;
    logic [3:0] newBe;
    logic [31:0] newData;
    logic [1:0] ldByteUnused;

    assign isSw    = (st_type == OP_SW);
    assign isSh    = (st_type == OP_SH);
    assign isSb    = (st_type == OP_SB);
    assign isLegal = isSw | isSh | isSb;
    assign isAligned = isSw ? (st_addr[1:0] == 2'b00) :
                       isSh ? ~st_addr[0] : 1'b1;

    assign st_ready     = (count != CW'(DEPTH));
    assign st_align_err = st_valid & isLegal & ~isAligned;
    assign doPush       = st_valid & st_ready & isLegal & isAligned;
    assign doPop        = mem_req & mem_ack;

    always_comb begin
        newBe   = '0;
        newData = '0;
        if (isSw) begin
            newBe   = 4'b1111;
            newData = st_data;
        end else if (isSh) begin
            newBe   = st_addr[1] ? 4'b1100 : 4'b0011;
            newData = {2{st_data[15:0]}};
        end else if (isSb) begin
            newBe   = 4'b0001 << st_addr[1:0];
            newData = {4{st_data[7:0]}};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            validQ  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addrQ[i] <= '0;
                dataQ[i] <= '0;
                beQ[i]   <= '0;
            end
        end else begin
            // Push and pop never target the same slot: pop needs count>0 and
            // push needs count<DEPTH, so with both active head != tail.
            if (doPop) begin
                validQ[headPtr] <= 1'b0;
                headPtr         <= headPtr + 1'b1;
            end
            if (doPush) begin
                addrQ[tailPtr]  <= st_addr[31:2];
                dataQ[tailPtr]  <= newData;
                beQ[tailPtr]    <= newBe;
                validQ[tailPtr] <= 1'b1;
                tailPtr         <= tailPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty      = (count == '0);
    assign mem_req    = ~empty;
    assign mem_addr   = {addrQ[headPtr], 2'b00};
    assign mem_wdata  = dataQ[headPtr];
    assign mem_byteen = beQ[headPtr];

    // Byte offset is irrelevant to a word-granular hazard.
    assign ldByteUnused = ld_addr[1:0];

    always_comb begin
        ld_hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (validQ[i] && (addrQ[i] == ld_addr[31:2])) begin
                ld_hazard = 1'b1;
            end
        end
        ld_hazard = ld_hazard & ld_valid;
    end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
module tb_store_buffer_ctrl;

    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] NOP = 6'b000000;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [5:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_align_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic        mem_ack;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic [2:0]  count;
    logic        empty;

    store_buffer_ctrl #(.DEPTH(4), .CW(3)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
        .st_addr(st_addr), .st_data(st_data), .st_align_err(st_align_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byteen(mem_byteen), .mem_ack(mem_ack),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
        .count(count), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        stV;
        bit [5:0]  stT;
        bit [31:0] stA;
        bit [31:0] stD;
        bit        ack;
        bit        ldV;
        bit [31:0] ldA;
        bit        eReq;
        bit [31:0] eAddr;
        bit [31:0] eWd;
        bit [3:0]  eBe;
        bit [2:0]  eCnt;
        bit        eRdy;
        bit        eErr;
        bit        eHaz;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic v(input bit stV, input bit [5:0] stT, input bit [31:0] stA,
                     input bit [31:0] stD, input bit ack, input bit ldV,
                     input bit [31:0] ldA, input bit eReq, input bit [31:0] eAddr,
                     input bit [31:0] eWd, input bit [3:0] eBe, input bit [2:0] eCnt,
                     input bit eRdy, input bit eErr, input bit eHaz);
        vec_t r;
        r.stV = stV; r.stT = stT; r.stA = stA; r.stD = stD; r.ack = ack;
        r.ldV = ldV; r.ldA = ldA; r.eReq = eReq; r.eAddr = eAddr; r.eWd = eWd;
        r.eBe = eBe; r.eCnt = eCnt; r.eRdy = eRdy; r.eErr = eErr; r.eHaz = eHaz;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input bit stV, input bit [5:0] stT, input bit [31:0] stA,
                         input bit [31:0] stD, input bit ack, input bit ldV,
                         input bit [31:0] ldA);
        st_valid = stV; st_type = stT; st_addr = stA; st_data = stD;
        mem_ack = ack; ld_valid = ldV; ld_addr = ldA;
    endtask

    initial begin
        // stV type addr data ack ldV ldA | eReq eAddr eWd eBe eCnt eRdy eErr eHaz
        // Single SW, acked next cycle
        v(1, SW,  32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        v(0, NOP, 0, 0, 1, 0, 0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 1, 1, 0, 0);
        v(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // SB / SH lane handling
        v(1, SB,  32'h203, 32'h000000A5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        v(1, SH,  32'h206, 32'h00001234, 0, 0, 0, 1, 32'h200, 32'hA5A5A5A5, 4'h8, 1, 1, 0, 0);
        v(0, NOP, 0, 0, 1, 0, 0, 1, 32'h200, 32'hA5A5A5A5, 4'h8, 2, 1, 0, 0);
        v(0, NOP, 0, 0, 1, 0, 0, 1, 32'h204, 32'h12341234, 4'hC, 1, 1, 0, 0);
        v(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Fill to DEPTH, reject 5th, push+pop at count 3, order check
        v(1, SW,  32'h10, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        v(1, SW,  32'h14, 32'h2, 0, 0, 0, 1, 32'h10, 32'h1, 4'hF, 1, 1, 0, 0);
        v(1, SW,  32'h18, 32'h3, 0, 0, 0, 1, 32'h10, 32'h1, 4'hF, 2, 1, 0, 0);
        v(1, SW,  32'h1C, 32'h4, 0, 0, 0, 1, 32'h10, 32'h1, 4'hF, 3, 1, 0, 0);
        v(1, SW,  32'h20, 32'h5, 0, 0, 0, 1, 32'h10, 32'h1, 4'hF, 4, 0, 0, 0);
        v(0, NOP, 0, 0, 1, 0, 0, 1, 32'h10, 32'h1, 4'hF, 4, 0, 0, 0);
        v(1, SW,  32'h24, 32'h6, 1, 0, 0, 1, 32'h14, 32'h2, 4'hF, 3, 1, 0, 0);
        v(0, NOP, 0, 0, 1, 0, 0, 1, 32'h18, 32'h3, 4'hF, 3, 1, 0, 0);
        v(0, NOP, 0, 0, 1, 0, 0, 1, 32'h1C, 32'h4, 4'hF, 2, 1, 0, 0);
        v(0, NOP, 0, 0, 1, 0, 0, 1, 32'h24, 32'h6, 4'hF, 1, 1, 0, 0);
        v(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Misaligned and illegal opcodes
        v(1, SH,  32'h101, 32'h7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        v(1, SW,  32'h102, 32'h7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        v(1, LW,  32'h101, 32'h7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        v(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Load hazard: same-cycle push not compared, head counts while acked
        v(1, SW,  32'h300, 32'h55, 0, 1, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0);
        v(0, NOP, 0, 0, 0, 1, 32'h302, 1, 32'h300, 32'h55, 4'hF, 1, 1, 0, 1);
        v(0, NOP, 0, 0, 0, 0, 32'h300, 1, 32'h300, 32'h55, 4'hF, 1, 1, 0, 0);
        v(0, NOP, 0, 0, 0, 1, 32'h304, 1, 32'h300, 32'h55, 4'hF, 1, 1, 0, 0);
        v(0, NOP, 0, 0, 1, 1, 32'h302, 1, 32'h300, 32'h55, 4'hF, 1, 1, 0, 1);
        v(0, NOP, 0, 0, 1, 1, 32'h302, 0, 0, 0, 0, 0, 1, 0, 0);
        v(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        reset = 1'b0;
        drive(0, NOP, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   -1, 32'(mem_req), 32'd0);
        chk("rst_count", -1, 32'(count),   32'd0);
        chk("rst_empty", -1, 32'(empty),   32'd1);
        chk("rst_ready", -1, 32'(st_ready), 32'd1);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].stV, vecs[i].stT, vecs[i].stA, vecs[i].stD,
                  vecs[i].ack, vecs[i].ldV, vecs[i].ldA);
            #1;
            chk("mem_req",  i, 32'(mem_req),      32'(vecs[i].eReq));
            chk("count",    i, 32'(count),        32'(vecs[i].eCnt));
            chk("empty",    i, 32'(empty),        32'(vecs[i].eCnt == 0));
            chk("st_ready", i, 32'(st_ready),     32'(vecs[i].eRdy));
            chk("align",    i, 32'(st_align_err), 32'(vecs[i].eErr));
            chk("hazard",   i, 32'(ld_hazard),    32'(vecs[i].eHaz));
            if (vecs[i].eReq) begin
                chk("mem_addr",   i, mem_addr,         vecs[i].eAddr);
                chk("mem_wdata",  i, mem_wdata,        vecs[i].eWd);
                chk("mem_byteen", i, 32'(mem_byteen),  32'(vecs[i].eBe));
            end
        end

        // Asynchronous reset mid-drain drops all queued entries
        @(negedge clk); drive(1, SW, 32'h400, 32'hA, 0, 0, 0);
        @(negedge clk); drive(1, SW, 32'h404, 32'hB, 0, 0, 0);
        @(negedge clk); drive(1, SW, 32'h408, 32'hC, 0, 0, 0);
        @(negedge clk); drive(0, NOP, 0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_count", 100, 32'(count),  32'd3);
        chk("pre_rst_addr",  100, mem_addr,    32'h400);
        #2 reset = 1'b0;
        #1;
        chk("async_req",   101, 32'(mem_req), 32'd0);
        chk("async_count", 101, 32'(count),   32'd0);
        chk("async_empty", 101, 32'(empty),   32'd1);
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_req",   102 + k, 32'(mem_req), 32'd0);
            chk("post_rst_count", 102 + k, 32'(count),   32'd0);
        end
        @(negedge clk); drive(1, SW, 32'h500, 32'h00C0FFEE, 0, 0, 0);
        @(negedge clk); drive(0, NOP, 0, 0, 0, 0, 0);
        #1;
        chk("fresh_req",   110, 32'(mem_req), 32'd1);
        chk("fresh_addr",  110, mem_addr,     32'h500);
        chk("fresh_wdata", 110, mem_wdata,    32'h00C0FFEE);
        chk("fresh_count", 110, 32'(count),   32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
